htg_ad9213_mmcm_supervisor: RTL

Lock supervisor and reset sequencer for the HTG AD9213 sample-clock MMCM. Runs on a free-running fabric reference clock, drives the MMCM reset input and watches its LOCKED output. It restarts the MMCM on lock timeout or loss of lock. It holds the downstream ADC/DSP logic in reset until the MMCM has been continuously locked for a programmable interval.

---
 rtl/htg_ad9213_mmcm_supervisor.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/htg_ad9213_mmcm_supervisor.sv
// Lock supervisor and reset sequencer for the HTG AD9213 sample-clock MMCM.
// Restarts the MMCM on lock timeout or loss and holds dsp_rst until lock has been qualified.
module htg_ad9213_mmcm_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES  = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES   = 1024,
  parameter int unsigned RELEASE_DELAY_CYCLES = 256,
  parameter int unsigned CNT_W                = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mmcm_locked,
  input  logic       sw_reset,
  output logic       mmcm_rst,
  output logic       dsp_rst,
  output logic       ready,
  output logic [2:0] state,
  output logic [7:0] lock_loss_count,
  output logic [7:0] timeout_count
);

  localparam int unsigned EVT_W   = 8;
  localparam int unsigned SYNC_W  = 2;
  localparam logic [CNT_W-1:0] LD_PULSE   = CNT_W'(RST_PULSE_CYCLES);
  localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(LOCK_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LD_STABLE  = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] LD_RELEASE = CNT_W'(RELEASE_DELAY_CYCLES);
  localparam logic [EVT_W-1:0] EVT_MAX    = '1;

  typedef enum logic [2:0] {
    ST_RESET_MMCM = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_RELEASE    = 3'd3,
    ST_RUN        = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SYNC_W-1:0]  sync_q, sync_d;
  logic               mmcm_rst_q, mmcm_rst_d;
  logic               dsp_rst_q, dsp_rst_d;
  logic               ready_q, ready_d;
  logic [EVT_W-1:0]   loss_cnt_q, loss_cnt_d;
  logic [EVT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               locked_s;
  logic               cnt_done;

  function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
    return (v == EVT_MAX) ? v : v + EVT_W'(1);
  endfunction

  assign locked_s = sync_q[SYNC_W-1];
  assign cnt_done = (cnt_q <= CNT_W'(1));

  // Next state: cnt is reloaded on every state entry and counts down the dwell time.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q - CNT_W'(1);
    sync_d     = {sync_q[SYNC_W-2:0], mmcm_locked};
    loss_cnt_d = loss_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;

    case (state_q)
      ST_RESET_MMCM: begin
        if (sw_reset) begin
          cnt_d = LD_PULSE;
        end else if (cnt_done) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = LD_TIMEOUT;
        end
      end
      ST_WAIT_LOCK: begin
        if (sw_reset) begin
          state_d = ST_RESET_MMCM;
          cnt_d   = LD_PULSE;
        end else if (locked_s) begin
          state_d = ST_STABLE;
          cnt_d   = LD_STABLE;
        end else if (cnt_done) begin
          state_d   = ST_RESET_MMCM;
          cnt_d     = LD_PULSE;
          tmo_cnt_d = sat_inc(tmo_cnt_q);
        end
      end
      ST_STABLE: begin
        if (sw_reset) begin
          state_d = ST_RESET_MMCM;
          cnt_d   = LD_PULSE;
        end else if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = LD_TIMEOUT;
        end else if (cnt_done) begin
          state_d = ST_RELEASE;
          cnt_d   = LD_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (sw_reset || !locked_s) begin
          state_d = ST_RESET_MMCM;
          cnt_d   = LD_PULSE;
        end else if (cnt_done) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q;
        // A lock drop is counted even when sw_reset arrives in the same cycle.
        if (!locked_s) begin
          state_d    = ST_RESET_MMCM;
          cnt_d      = LD_PULSE;
          loss_cnt_d = sat_inc(loss_cnt_q);
        end else if (sw_reset) begin
          state_d = ST_RESET_MMCM;
          cnt_d   = LD_PULSE;
        end
      end
      default: begin
        state_d = ST_RESET_MMCM;
        cnt_d   = LD_PULSE;
      end
    endcase

    mmcm_rst_d = (state_d == ST_RESET_MMCM);
    dsp_rst_d  = (state_d != ST_RUN);
    ready_d    = (state_d == ST_RUN);
  end

  // State, counter, synchronizer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RESET_MMCM;
      cnt_q      <= LD_PULSE;
      sync_q     <= '0;
      mmcm_rst_q <= 1'b1;
      dsp_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      loss_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync_q     <= sync_d;
      mmcm_rst_q <= mmcm_rst_d;
      dsp_rst_q  <= dsp_rst_d;
      ready_q    <= ready_d;
      loss_cnt_q <= loss_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign mmcm_rst        = mmcm_rst_q;
  assign dsp_rst         = dsp_rst_q;
  assign ready           = ready_q;
  assign state           = state_q;
  assign lock_loss_count = loss_cnt_q;
  assign timeout_count   = tmo_cnt_q;

endmodule
